// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage: branch-destination codes, FSM states,
// and instruction field positions.
package fetch_pkg;

  localparam logic [2:0] BR_SEQ    = 3'd0;
  localparam logic [2:0] BR_SKIP_T = 3'd1;
  localparam logic [2:0] BR_JMP_A  = 3'd2;
  localparam logic [2:0] BR_JMP_B  = 3'd3;
  localparam logic [2:0] BR_BR_A_T = 3'd4;
  localparam logic [2:0] BR_SKIP_F = 3'd5;
  localparam logic [2:0] BR_HALT   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int OPCODE_MSB   = 9;
  localparam int OPCODE_LSB   = 6;
  localparam int OPERAND_MSB  = 5;
  localparam int ARG2_BIT     = 1;
  localparam int BIT0_BIT     = 0;

  localparam logic [3:0] INVALID_OPCODE = 4'hF;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-facing bus of the fetch stage.
// master = fetch_unit, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 10
);
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [3:0]             opcode;
  logic [4:0]             five_to_one;
  logic [1:0]             one_to_zero;
  logic                   arg2;
  logic                   bit0;
  logic                   instr_valid;
  logic [2:0]             branch_dest;
  logic                   branch_cond;
  logic [PC_WIDTH-1:0]    target_a;
  logic [PC_WIDTH-1:0]    target_b;

  modport master (
    output imem_addr, opcode, five_to_one, one_to_zero, arg2, bit0, instr_valid,
    input  imem_data, branch_dest, branch_cond, target_a, target_b
  );

  modport slave (
    input  imem_addr, opcode, five_to_one, one_to_zero, arg2, bit0, instr_valid,
    output imem_data, branch_dest, branch_cond, target_a, target_b
  );
endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection from decode's branch-destination code.
// All arithmetic wraps modulo 2^PC_WIDTH.
module next_pc_mux
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int HALT_PC  = 200
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [2:0]          branch_dest,
  input  logic                branch_cond,
  input  logic [PC_WIDTH-1:0] target_a,
  input  logic [PC_WIDTH-1:0] target_b,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                halt,
  output logic                illegal
);

  logic [PC_WIDTH-1:0] pc_inc1;
  logic [PC_WIDTH-1:0] pc_inc2;

  assign pc_inc1 = pc + PC_WIDTH'(1);
  assign pc_inc2 = pc + PC_WIDTH'(2);

  always_comb begin
    next_pc = pc_inc1;
    halt    = 1'b0;
    illegal = 1'b0;
    case (branch_dest)
      BR_SEQ:    next_pc = pc_inc1;
      BR_SKIP_T: next_pc = branch_cond ? pc_inc2 : pc_inc1;
      BR_JMP_A:  next_pc = target_a;
      BR_JMP_B:  next_pc = target_b;
      BR_BR_A_T: next_pc = branch_cond ? target_a : pc_inc1;
      BR_SKIP_F: next_pc = branch_cond ? pc_inc1 : pc_inc2;
      BR_HALT: begin
        next_pc = PC_WIDTH'(HALT_PC);
        halt    = 1'b1;
      end
      default: begin
        next_pc = pc_inc1;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the IDLE/RUN/HALTED machine, the
// retired-instruction counter and the sticky illegal-branch flag.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 10,
  parameter int RESET_PC    = 0,
  parameter int HALT_PC     = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  fetch_unit_if.master        bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                running,
  output logic                halted,
  output logic [15:0]         instr_count,
  output logic                illegal_branch
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] HALT_PC_V  = PC_WIDTH'(HALT_PC);

  state_e              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [15:0]         count_reg, count_next;
  logic                illegal_reg, illegal_next;

  logic [PC_WIDTH-1:0] mux_pc;
  logic                mux_halt;
  logic                mux_illegal;
  logic                valid;

  next_pc_mux #(
    .PC_WIDTH (PC_WIDTH),
    .HALT_PC  (HALT_PC)
  ) u_next_pc_mux (
    .pc          (pc_reg),
    .branch_dest (bus.branch_dest),
    .branch_cond (bus.branch_cond),
    .target_a    (bus.target_a),
    .target_b    (bus.target_b),
    .next_pc     (mux_pc),
    .halt        (mux_halt),
    .illegal     (mux_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC_V;
      count_reg   <= 16'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      count_reg   <= count_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    count_next   = count_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        pc_next = mux_pc;
        // The HALT instruction itself still retires and is counted.
        if (count_reg != 16'hFFFF) count_next = count_reg + 16'd1;
        if (mux_illegal) illegal_next = 1'b1;
        if (mux_halt) state_next = ST_HALTED;
      end
      ST_HALTED: begin
        pc_next = HALT_PC_V;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign valid = (state_reg == ST_RUN);

  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = valid;
  assign bus.opcode      = valid ? bus.imem_data[OPCODE_MSB:OPCODE_LSB] : INVALID_OPCODE;
  assign bus.five_to_one = valid ? bus.imem_data[OPERAND_MSB:ARG2_BIT] : 5'd0;
  assign bus.one_to_zero = valid ? bus.imem_data[ARG2_BIT:BIT0_BIT] : 2'd0;
  assign bus.arg2        = valid & bus.imem_data[ARG2_BIT];
  assign bus.bit0        = valid & bus.imem_data[BIT0_BIT];

  assign pc             = pc_reg;
  assign pc_plus1       = pc_reg + PC_WIDTH'(1);
  assign running        = valid;
  assign halted         = (state_reg == ST_HALTED);
  assign instr_count    = count_reg;
  assign illegal_branch = illegal_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table of branch codes with
// expected PCs, a scoreboard queue of post-edge results, and hand-written
// halt / mid-run reset sequences.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  pc;
  logic [7:0]  pc_plus1;
  logic        running;
  logic        halted;
  logic [15:0] instr_count;
  logic        illegal_branch;

  fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(10)) bus ();

  fetch_unit #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (10),
    .RESET_PC    (0),
    .HALT_PC     (200)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bus            (bus),
    .pc             (pc),
    .pc_plus1       (pc_plus1),
    .running        (running),
    .halted         (halted),
    .instr_count    (instr_count),
    .illegal_branch (illegal_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] bd;
    logic       cond;
    logic [7:0] ta;
    logic [7:0] tb;
    logic [7:0] exp_pc;
    logic       exp_ill;
    logic       exp_halt;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic        ill;
    logic        halt;
    logic [15:0] count;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic idle_checks(input logic [7:0] epc, input logic [15:0] ecnt,
                             input logic eill, input logic ehalt, input string tag);
    check({tag, "_pc"}, pc, epc);
    check({tag, "_valid"}, bus.instr_valid, 1'b0);
    check({tag, "_opcode"}, bus.opcode, 4'hF);
    check({tag, "_count"}, instr_count, ecnt);
    check({tag, "_illegal"}, illegal_branch, eill);
    check({tag, "_halted"}, halted, ehalt);
    check({tag, "_running"}, running, 1'b0);
  endtask

  initial begin
    logic [9:0] data;
    logic [7:0] model_pc;
    exp_t       e;

    vecs[0]  = '{3'd0, 1'b0, 8'd0,   8'd0,   8'd1,   1'b0, 1'b0};
    vecs[1]  = '{3'd0, 1'b0, 8'd0,   8'd0,   8'd2,   1'b0, 1'b0};
    vecs[2]  = '{3'd0, 1'b0, 8'd0,   8'd0,   8'd3,   1'b0, 1'b0};
    vecs[3]  = '{3'd0, 1'b1, 8'd0,   8'd0,   8'd4,   1'b0, 1'b0};
    vecs[4]  = '{3'd1, 1'b1, 8'd0,   8'd0,   8'd6,   1'b0, 1'b0};
    vecs[5]  = '{3'd5, 1'b1, 8'd0,   8'd0,   8'd7,   1'b0, 1'b0};
    vecs[6]  = '{3'd4, 1'b0, 8'd2,   8'd0,   8'd8,   1'b0, 1'b0};
    vecs[7]  = '{3'd4, 1'b1, 8'd2,   8'd0,   8'd2,   1'b0, 1'b0};
    vecs[8]  = '{3'd3, 1'b0, 8'd0,   8'd255, 8'd255, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 1'b1, 8'd0,   8'd0,   8'd1,   1'b0, 1'b0};
    vecs[10] = '{3'd7, 1'b0, 8'd0,   8'd0,   8'd2,   1'b1, 1'b0};
    vecs[11] = '{3'd2, 1'b0, 8'd254, 8'd0,   8'd254, 1'b1, 1'b0};
    vecs[12] = '{3'd5, 1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0};
    vecs[13] = '{3'd2, 1'b0, 8'd9,   8'd0,   8'd9,   1'b1, 1'b0};
    vecs[14] = '{3'd6, 1'b0, 8'd0,   8'd0,   8'd200, 1'b1, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    bus.imem_data   = 10'b0101_000010;
    bus.branch_dest = 3'd0;
    bus.branch_cond = 1'b0;
    bus.target_a    = 8'd0;
    bus.target_b    = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_checks(8'd0, 16'd0, 1'b0, 1'b0, "reset");

    repeat (5) @(posedge clk);
    #1 idle_checks(8'd0, 16'd0, 1'b0, 1'b0, "idle5");
    check("idle_imem_addr", bus.imem_addr, 8'd0);
    $display("idle hold: pc=%0d count=%0d", pc, instr_count);

    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_running", running, 1'b1);
    check("start_valid", bus.instr_valid, 1'b1);
    check("start_pc", pc, 8'd0);
    model_pc = 8'd0;

    for (int i = 0; i < 15; i++) begin
      data = (i == 0) ? 10'b0101_000010 : 10'($urandom_range(0, 1023));
      bus.imem_data   = data;
      bus.branch_dest = vecs[i].bd;
      bus.branch_cond = vecs[i].cond;
      bus.target_a    = vecs[i].ta;
      bus.target_b    = vecs[i].tb;
      #1;
      check("imem_addr", bus.imem_addr, model_pc);
      check("pc_plus1", pc_plus1, 8'(model_pc + 8'd1));
      if (i == 0) begin
        check("opcode_word", bus.opcode, 4'd5);
        check("one_to_zero_word", bus.one_to_zero, 2'd2);
      end else begin
        check("opcode", bus.opcode, data[9:6]);
        check("five_to_one", bus.five_to_one, data[5:1]);
        check("one_to_zero", bus.one_to_zero, data[1:0]);
        check("arg2", bus.arg2, data[1]);
        check("bit0", bus.bit0, data[0]);
      end
      sb.push_back('{vecs[i].exp_pc, vecs[i].exp_ill, vecs[i].exp_halt, 16'(i + 1)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("vec_pc", pc, e.pc);
      check("vec_illegal", illegal_branch, e.ill);
      check("vec_halted", halted, e.halt);
      check("vec_count", instr_count, e.count);
      $display("vec %0d: bd=%0d cond=%0d pc=%0d exp=%0d count=%0d", i, vecs[i].bd,
               vecs[i].cond, pc, e.pc, instr_count);
      model_pc = e.pc;
    end

    idle_checks(8'd200, 16'd15, 1'b1, 1'b1, "halt");
    check("halt_five_to_one", bus.five_to_one, 5'd0);

    bus.branch_dest = 3'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 idle_checks(8'd200, 16'd15, 1'b1, 1'b1, "halt_start");
    $display("halted hold: pc=%0d halted=%0d", pc, halted);

    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    idle_checks(8'd0, 16'd0, 1'b0, 1'b0, "halt_reset");

    start = 1'b1;
    bus.branch_dest = 3'd7;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 check("mid_pc1", pc, 8'd1);
    check("mid_illegal", illegal_branch, 1'b1);
    bus.branch_dest = 3'd0;
    @(posedge clk);
    #1 check("mid_pc2", pc, 8'd2);
    check("mid_count", instr_count, 16'd2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    idle_checks(8'd0, 16'd0, 1'b0, 1'b0, "mid_reset");
    $display("mid-run reset: pc=%0d count=%0d illegal=%0d", pc, instr_count, illegal_branch);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
